board_click_decoder: RTL and testbench

BOARD_CLICK_DECODER -- requirements
Module: board_click_decoder

---
 rtl/game_pkg.sv | 26 ++
 rtl/field_coord_div.sv | 89 ++++++++
 rtl/board_click_decoder.sv | 164 ++++++++++++++++
 tb/tb_board_click_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level types: top-level game state encoding, click type and
// the click decoder FSM state.
package game_pkg;

  typedef enum logic [2:0] {
    GAME_START = 3'd0,
    PLAY       = 3'd1,
    GAME_OVER  = 3'd2,
    GAME_WIN   = 3'd3
  } game_state_t;

  typedef enum logic {
    CLICK_LEFT  = 1'b0,
    CLICK_RIGHT = 1'b1
  } click_t;

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_CAPTURE = 2'd1,
    DEC_DIV     = 2'd2,
    DEC_HOLD    = 2'd3
  } dec_state_t;

  localparam int unsigned FIELD_SIZE_W = 6;

endpackage

// File: rtl/field_coord_div.sv
// Per-axis field index finder: repeatedly subtracts the field size from a
// board-relative pixel offset, one step per clock, counting the steps.
module field_coord_div
  import game_pkg::*;
#(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [COORD_W-1:0]      rel_i,
  input  logic [FIELD_SIZE_W-1:0] size_i,
  input  logic [IDX_W-1:0]        num_i,
  output logic                    done_o,
  output logic                    err_o,
  output logic [IDX_W-1:0]        idx_o
);

  logic [COORD_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [COORD_W-1:0] size_ext;
  logic [IDX_W-1:0]   last_idx;
  logic               res_below;

  assign size_ext  = COORD_W'(size_i);
  assign last_idx  = num_i - IDX_W'(1);
  assign res_below = (res_q < size_ext);

  // Next-state: load on start, then one subtract/increment step per cycle
  // until the residual fits in one field or the index saturates.
  always_comb begin
    res_d  = res_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    if (clear_i) begin
      busy_d = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (start_i) begin
      res_d  = rel_i;
      idx_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (busy_q) begin
      if (res_below) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (idx_q == last_idx) begin
        // Index would pass the last field: geometry changed under us.
        busy_d = 1'b0;
        err_d  = 1'b1;
      end else begin
        res_d = res_q - size_ext;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/board_click_decoder.sv
// Turns mouse button presses over the game board into (row, col, type)
// click transactions with a valid/ready handshake towards the game logic.
module board_click_decoder
  import game_pkg::*;
#(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              main_state,
  input  logic [COORD_W-1:0]      mouse_xpos,
  input  logic [COORD_W-1:0]      mouse_ypos,
  input  logic                    left,
  input  logic                    right,
  input  logic [COORD_W-1:0]      board_xpos,
  input  logic [COORD_W-1:0]      board_ypos,
  input  logic [FIELD_SIZE_W-1:0] field_size,
  input  logic [IDX_W-1:0]        field_num,
  output logic                    click_valid,
  input  logic                    click_ready,
  output logic [IDX_W-1:0]        field_row,
  output logic [IDX_W-1:0]        field_col,
  output click_t                  click_type
);

  localparam int unsigned EXT_W = COORD_W + IDX_W + FIELD_SIZE_W;

  logic               left_q, right_q, hist_ok_q;
  logic               left_rise, right_rise, play;

  dec_state_t         state_q;
  logic [COORD_W-1:0] x_q, y_q;
  click_t             type_q;
  logic               valid_q;
  logic [IDX_W-1:0]   row_q, col_q;
  click_t             ctype_q;

  logic [COORD_W-1:0] rel_x, rel_y;
  logic [EXT_W-1:0]   span;
  logic               in_x, in_y, geom_ok, cap_ok;
  logic               div_start, div_clear;
  logic               done_x, done_y, err_x, err_y;
  logic [IDX_W-1:0]   idx_x, idx_y;

  // Button history; hist_ok_q suppresses edges on the first cycle after
  // reset so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      hist_ok_q <= 1'b0;
    end else begin
      left_q    <= left;
      right_q   <= right;
      hist_ok_q <= 1'b1;
    end
  end

  // Edge pulses, play gating and board bounds check on the latched position.
  always_comb begin
    left_rise  = left  & ~left_q  & hist_ok_q;
    right_rise = right & ~right_q & hist_ok_q;
    play       = (main_state == PLAY);
    rel_x      = x_q - board_xpos;
    rel_y      = y_q - board_ypos;
    span       = EXT_W'(field_num) * EXT_W'(field_size);
    in_x       = (x_q >= board_xpos) && (EXT_W'(rel_x) < span);
    in_y       = (y_q >= board_ypos) && (EXT_W'(rel_y) < span);
    geom_ok    = (field_size != '0) && (field_num != '0);
    cap_ok     = in_x && in_y && geom_ok;
    div_start  = (state_q == DEC_CAPTURE) && play && cap_ok;
    div_clear  = !play;
  end

  field_coord_div #(
    .COORD_W(COORD_W),
    .IDX_W  (IDX_W)
  ) u_div_x (
    .clk_i  (clk),
    .rst_ni (rst),
    .clear_i(div_clear),
    .start_i(div_start),
    .rel_i  (rel_x),
    .size_i (field_size),
    .num_i  (field_num),
    .done_o (done_x),
    .err_o  (err_x),
    .idx_o  (idx_x)
  );

  field_coord_div #(
    .COORD_W(COORD_W),
    .IDX_W  (IDX_W)
  ) u_div_y (
    .clk_i  (clk),
    .rst_ni (rst),
    .clear_i(div_clear),
    .start_i(div_start),
    .rel_i  (rel_y),
    .size_i (field_size),
    .num_i  (field_num),
    .done_o (done_y),
    .err_o  (err_y),
    .idx_o  (idx_y)
  );

  // Decoder FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DEC_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= CLICK_LEFT;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      ctype_q <= CLICK_LEFT;
    end else begin
      case (state_q)
        DEC_IDLE: begin
          valid_q <= 1'b0;
          // A chord (both edges in one cycle) is ambiguous and dropped.
          if (play && (left_rise ^ right_rise)) begin
            x_q     <= mouse_xpos;
            y_q     <= mouse_ypos;
            type_q  <= right_rise ? CLICK_RIGHT : CLICK_LEFT;
            state_q <= DEC_CAPTURE;
          end
        end
        DEC_CAPTURE: begin
          state_q <= (play && cap_ok) ? DEC_DIV : DEC_IDLE;
        end
        DEC_DIV: begin
          if (!play || err_x || err_y) begin
            state_q <= DEC_IDLE;
          end else if (done_x && done_y) begin
            state_q <= DEC_HOLD;
            valid_q <= 1'b1;
            row_q   <= idx_y;
            col_q   <= idx_x;
            ctype_q <= type_q;
          end
        end
        DEC_HOLD: begin
          if (!play || click_ready) begin
            state_q <= DEC_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DEC_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign click_valid = valid_q;
  assign field_row   = row_q;
  assign field_col   = col_q;
  assign click_type  = ctype_q;

endmodule

// File: tb/tb_board_click_decoder.sv
// Self-checking bench for board_click_decoder: directed clicks against a
// timeline model derived from the board geometry and latency rules.
module tb_board_click_decoder;
  import game_pkg::*;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned IDX_W   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         main_state = 3'd1;
  logic [COORD_W-1:0] mouse_xpos = '0, mouse_ypos = '0;
  logic               left = 1'b0, right = 1'b0;
  logic [COORD_W-1:0] board_xpos = 12'd100, board_ypos = 12'd50;
  logic [5:0]         field_size = 6'd40;
  logic [IDX_W-1:0]   field_num = 5'd10;
  logic               click_valid;
  logic               click_ready = 1'b1;
  logic [IDX_W-1:0]   field_row, field_col;
  click_t             click_type;

  board_click_decoder #(.COORD_W(COORD_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .main_state (main_state),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .left       (left),
    .right      (right),
    .board_xpos (board_xpos),
    .board_ypos (board_ypos),
    .field_size (field_size),
    .field_num  (field_num),
    .click_valid(click_valid),
    .click_ready(click_ready),
    .field_row  (field_row),
    .field_col  (field_col),
    .click_type (click_type)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic v_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: an accepted press becomes valid 3 + max(row,col)
  // clocks later (or, out of bounds, frees the decoder after one clock).
  int   cyc = 0;
  logic m_lq = 1'b0, m_rq = 1'b0, m_armed = 1'b0;
  logic m_busy = 1'b0, m_out = 1'b0, m_valid = 1'b0;
  int   m_due = 0, m_row = 0, m_col = 0, p_row = 0, p_col = 0;
  logic m_type = 1'b0, p_type = 1'b0;
  logic le, re, mplay;
  int   rx, ry, ext;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lq = 1'b0; m_rq = 1'b0; m_armed = 1'b0;
      m_busy = 1'b0; m_out = 1'b0; m_valid = 1'b0;
    end else begin
      cyc++;
      le    = left  && !m_lq && m_armed;
      re    = right && !m_rq && m_armed;
      mplay = (main_state == 3'd1);
      if (m_valid) begin
        if (!mplay || click_ready) m_valid = 1'b0;
      end else if (m_busy) begin
        if (!mplay) m_busy = 1'b0;
        else if (cyc == m_due) begin
          m_busy = 1'b0;
          if (m_out) begin
            m_valid = 1'b1; m_row = p_row; m_col = p_col; m_type = p_type;
          end
        end
      end else if (mplay && (le != re)) begin
        rx  = int'(mouse_xpos) - int'(board_xpos);
        ry  = int'(mouse_ypos) - int'(board_ypos);
        ext = int'(field_num) * int'(field_size);
        m_busy = 1'b1;
        if (rx >= 0 && ry >= 0 && rx < ext && ry < ext) begin
          p_col  = rx / int'(field_size);
          p_row  = ry / int'(field_size);
          p_type = re;
          m_out  = 1'b1;
          m_due  = cyc + 3 + ((p_row > p_col) ? p_row : p_col);
        end else begin
          m_out = 1'b0;
          m_due = cyc + 1;
        end
      end
      m_lq = left; m_rq = right; m_armed = 1'b1;
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (click_valid && !v_prev) rises++;
    v_prev = click_valid;
    if (rst) begin
      check("valid", click_valid, m_valid);
      if (m_valid) begin
        check("row", field_row, m_row);
        check("col", field_col, m_col);
        check("type", click_type, m_type);
      end
    end
  end

  task automatic click_lat(input logic is_r, input int x, input int y, output int lat);
    @(negedge clk);
    mouse_xpos = COORD_W'(x);
    mouse_ypos = COORD_W'(y);
    if (is_r) right = 1'b1; else left = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin left = 1'b0; right = 1'b0; end
      if (click_valid) begin lat = k; break; end
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (click_valid) cnt++;
    end
    check(name, cnt, 0);
  endtask

  task automatic press(input logic is_r, input int x, input int y);
    @(negedge clk);
    mouse_xpos = COORD_W'(x);
    mouse_ypos = COORD_W'(y);
    if (is_r) right = 1'b1; else left = 1'b1;
    @(negedge clk);
    left = 1'b0; right = 1'b0;
  endtask

  int   vr[6]   = '{0, 1, 0, 0, 1, 1};
  int   vx[6]   = '{100, 499, 140, 260, 100, 139};
  int   vy[6]   = '{50, 449, 50, 449, 130, 89};
  int   vlat[6] = '{3, 12, 4, 12, 5, 3};
  int   vrow[6] = '{0, 9, 0, 9, 2, 0};
  int   vcol[6] = '{0, 9, 1, 4, 0, 0};

  initial begin
    int lat;
    int r0;

    repeat (3) @(negedge clk);
    check("rst_valid", click_valid, 0);
    check("rst_row", field_row, 0);
    check("rst_col", field_col, 0);
    check("rst_type", click_type, CLICK_LEFT);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed clicks with ready already high.
    for (int i = 0; i < 6; i++) begin
      click_lat(vr[i][0], vx[i], vy[i], lat);
      check($sformatf("v%0d_lat", i), lat, vlat[i]);
      check($sformatf("v%0d_row", i), field_row, vrow[i]);
      check($sformatf("v%0d_col", i), field_col, vcol[i]);
      check($sformatf("v%0d_type", i), click_type, vr[i][0]);
      @(negedge clk);
      check($sformatf("v%0d_drop", i), click_valid, 0);
      repeat (2) @(negedge clk);
    end

    // Out-of-bounds clicks.
    press(1'b0, 500, 449);
    expect_quiet("oob_x_hi", 20);
    press(1'b0, 99, 50);
    expect_quiet("oob_x_lo", 20);

    // Held click with a second press during hold.
    click_ready = 1'b0;
    r0 = rises;
    click_lat(1'b0, 185, 135, lat);
    check("hold_lat", lat, 5);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) left = 1'b1;
      if (i == 3) left = 1'b0;
      check("hold_valid", click_valid, 1);
      check("hold_row", field_row, 2);
      check("hold_col", field_col, 2);
      @(negedge clk);
    end
    click_ready = 1'b1;
    @(negedge clk);
    check("hold_release", click_valid, 0);
    expect_quiet("hold_no_second", 20);
    check("hold_one_xfer", rises - r0, 1);

    // Leaving PLAY four clocks after the press.
    press(1'b0, 460, 450);
    repeat (3) @(negedge clk);
    main_state = 3'd2;
    expect_quiet("gameover_oob", 20);
    check("gameover_fsm_idle", dut.state_q, DEC_IDLE);
    main_state = 3'd1;
    press(1'b0, 499, 449);
    repeat (3) @(negedge clk);
    main_state = 3'd2;
    expect_quiet("gameover_div", 20);
    check("gameover_div_idle", dut.state_q, DEC_IDLE);
    main_state = 3'd1;
    repeat (2) @(negedge clk);

    // Chord.
    @(negedge clk);
    mouse_xpos = 12'd150; mouse_ypos = 12'd60;
    left = 1'b1; right = 1'b1;
    @(negedge clk);
    left = 1'b0; right = 1'b0;
    expect_quiet("chord", 20);

    // Reset asserted while holding a right click, left held across release.
    click_ready = 1'b0;
    click_lat(1'b1, 185, 135, lat);
    check("rh_lat", lat, 5);
    check("rh_type", click_type, CLICK_RIGHT);
    @(negedge clk);
    left = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rh_valid_now", click_valid, 0);
    check("rh_row_now", field_row, 0);
    check("rh_col_now", field_col, 0);
    check("rh_type_now", click_type, CLICK_LEFT);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    click_ready = 1'b1;
    expect_quiet("rh_held_release", 20);
    left = 1'b0;

    // Reset during DIV with right held across release.
    @(negedge clk);
    mouse_xpos = 12'd499; mouse_ypos = 12'd449;
    right = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rd_valid_now", click_valid, 0);
    check("rd_fsm_now", dut.state_q, DEC_IDLE);
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("rd_held_release", 20);
    right = 1'b0;

    // Zero field size.
    @(negedge clk);
    field_size = 6'd0;
    press(1'b0, 120, 60);
    expect_quiet("size_zero", 10);
    field_size = 6'd40;

    // Decoder still works afterwards.
    click_lat(1'b0, 185, 135, lat);
    check("final_lat", lat, 5);
    check("final_row", field_row, 2);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
